// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter.
// State encoding, tag byte base and frame-gap helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Source tag byte is TAG_BASE | requester index.
  localparam logic [7:0] TAG_BASE = 8'hF0;

  // Start + 8 data + stop bits, plus one spare cycle so the
  // transmitter has finished before the next strobe arrives.
  function automatic int frame_gap(input int tpb);
    return 10 * tpb + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports: valid_i, ptr_i (last winner) -> win_o (one-hot), idx_o, any_o.
module uart_tx_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic found;

  // Search ptr+1, ptr+2, ... so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win_o = '0;
    idx_o = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (!found && valid_i[j]) begin
        found    = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one static-baud UART TX.
// Ports: clk, rst (sync, active-high), req_valid/req_data/req_last/
// req_ready per requester, tx_stb/tx_data to the transmitter,
// grant (one-hot owner), busy. Optional source-tag prefix byte when
// UART_TX_ARBITER_TAG_EN is defined.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TICKS_PER_BAUD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_stb,
  output logic [7:0]           tx_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int FG = frame_gap(TICKS_PER_BAUD);
  localparam int CW = $clog2(FG + 1);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] GAP_LOAD = CW'(FG - 1);

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      idx_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic               last_q;
  logic               tx_stb_q;
  logic [7:0]         tx_data_q;

  logic [NUM_REQ-1:0] win;
  logic [PW-1:0]      win_idx;
  logic               any;

  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  uart_tx_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .idx_o   (win_idx),
    .any_o   (any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx_q == PW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign cnt_d = cnt_q - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PW'(NUM_REQ - 1);
      idx_q     <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_stb_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any) begin
            grant_q <= win;
            ptr_q   <= win_idx;
            idx_q   <= win_idx;
`ifdef UART_TX_ARBITER_TAG_EN
            state_q <= TAG;
`else
            state_q <= SEND;
`endif
          end
        end
`ifdef UART_TX_ARBITER_TAG_EN
        TAG: begin
          tx_stb_q  <= 1'b1;
          tx_data_q <= TAG_BASE | {4'h0, 4'(idx_q)};
          last_q    <= 1'b0;
          cnt_q     <= GAP_LOAD;
          state_q   <= GAP;
        end
`endif
        SEND: begin
          if (sel_valid) begin
            tx_stb_q  <= 1'b1;
            tx_data_q <= sel_data;
            last_q    <= sel_last;
            cnt_q     <= GAP_LOAD;
            state_q   <= GAP;
          end
        end
        GAP: begin
          cnt_q <= cnt_d;
          // Leave as the counter reaches zero so the next strobe
          // lands exactly FG cycles after the previous one.
          if (cnt_d == '0) begin
            if (last_q) begin
              grant_q <= '0;
              state_q <= IDLE;
            end else begin
              state_q <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == SEND) ? grant_q : '0;
  assign tx_stb    = tx_stb_q;
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=2, TICKS_PER_BAUD=4).
// Wire order and strobe spacing are predicted from packet queues.
module tb_uart_tx_arbiter;

  localparam int FG = 41;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_stb;
  logic [7:0]  tx_data;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc;
  int model_ptr;

  logic [8:0] srcq[2][$];
  int         stall_cnt[2];
  bit         stall_arm[2];
  logic [1:0] stall_grant;

  int         obs_cyc[$];
  logic [7:0] obs_data[$];
  logic [1:0] obs_grant[$];

  int         exp_gap[$];
  logic [7:0] exp_data[$];
  logic [1:0] exp_grant[$];

  uart_tx_arbiter #(
    .NUM_REQ        (2),
    .TICKS_PER_BAUD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_stb    (tx_stb),
    .tx_data   (tx_data),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic drive();
    logic [8:0] e;
    for (int r = 0; r < 2; r++) begin
      if (srcq[r].size() > 0 && stall_cnt[r] == 0) begin
        e = srcq[r][0];
        req_valid[r]       = 1'b1;
        req_data[8*r +: 8] = e[7:0];
        req_last[r]        = e[8];
      end else begin
        req_valid[r]       = 1'b0;
        req_data[8*r +: 8] = 8'($urandom);
        req_last[r]        = 1'($urandom);
      end
    end
  endtask

  task automatic step();
    logic [1:0] hs;
    @(negedge clk);
    cyc++;
    if (tx_stb) begin
      obs_cyc.push_back(cyc);
      obs_data.push_back(tx_data);
      obs_grant.push_back(grant);
    end
    hs = req_valid & req_ready;
    if (hs != 2'b00 && hs_cyc < 0) hs_cyc = cyc;
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (stall_cnt[r] > 0) stall_cnt[r]--;
      if (hs[r]) begin
        if (srcq[r].size() > 0) void'(srcq[r].pop_front());
        if (stall_arm[r]) begin
          stall_cnt[r] = 100;
          stall_arm[r] = 1'b0;
        end
      end
    end
    if (stall_cnt[0] == 50) stall_grant = grant;
    drive();
  endtask

  // Reference: whole packets leave in round-robin order starting after
  // the last winner; 41 cycles inside a packet, 42 between packets.
  task automatic build_expected();
    logic [8:0] cq[2][$];
    logic [8:0] e;
    int ptr, r, g;
    bit first, found;
    for (int i = 0; i < 2; i++) cq[i] = srcq[i];
    exp_gap.delete();
    exp_data.delete();
    exp_grant.delete();
    ptr = model_ptr;
    first = 1'b1;
    while (cq[0].size() > 0 || cq[1].size() > 0) begin
      found = 1'b0;
      r = 0;
      for (int k = 1; k <= 2; k++) begin
        if (!found && cq[(ptr + k) % 2].size() > 0) begin
          r = (ptr + k) % 2;
          found = 1'b1;
        end
      end
      g = first ? 0 : FG + 1;
`ifdef UART_TX_ARBITER_TAG_EN
      exp_data.push_back(8'hF0 | 8'(r));
      exp_grant.push_back(2'(1 << r));
      exp_gap.push_back(g);
      g = FG;
`endif
      do begin
        e = cq[r].pop_front();
        exp_data.push_back(e[7:0]);
        exp_grant.push_back(2'(1 << r));
        exp_gap.push_back(g);
        g = FG;
      end while (!e[8]);
      ptr = r;
      first = 1'b0;
    end
    model_ptr = ptr;
  endtask

  task automatic run_and_check(input string name, input bit stall_mode);
    int n, m, d;
    build_expected();
    obs_cyc.delete();
    obs_data.delete();
    obs_grant.delete();
    hs_cyc = -1;
    drive();
    n = 0;
    while ((srcq[0].size() > 0 || srcq[1].size() > 0 || busy) && n < 5000) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL %s timeout: got %0d cycles want <5000", name, n);
    end
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL %s count: got %0d want %0d", name, obs_data.size(), exp_data.size());
    end
    m = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL %s data[%0d]: got %h want %h", name, i, obs_data[i], exp_data[i]);
      end
      checks++;
      if (obs_grant[i] !== exp_grant[i]) begin
        failures++;
        $display("FAIL %s grant[%0d]: got %b want %b", name, i, obs_grant[i], exp_grant[i]);
      end
      if (i > 0 && exp_gap[i] > 0) begin
        d = obs_cyc[i] - obs_cyc[i-1];
        checks++;
        if (stall_mode && exp_gap[i] == FG) begin
          if (d < FG) begin
            failures++;
            $display("FAIL %s gap[%0d]: got %0d want >=%0d", name, i, d, FG);
          end
        end else if (d != exp_gap[i]) begin
          failures++;
          $display("FAIL %s gap[%0d]: got %0d want %0d", name, i, d, exp_gap[i]);
        end
      end
    end
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: got grant=%b busy=%b want 00/0", name, grant, busy);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (tx_stb !== 1'b0 || tx_data !== 8'h00 || grant !== 2'b00 ||
        busy !== 1'b0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL %s: got stb=%b data=%h grant=%b busy=%b ready=%b want all 0",
               name, tx_stb, tx_data, grant, busy, req_ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    srcq[0].delete();
    srcq[1].delete();
    repeat (2) step();
    rst = 1'b0;
    model_ptr = 1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    repeat (3) step();
    check_zero("reset_initial");
    rst = 1'b0;
    model_ptr = 1;
    srcq[1].push_back({1'b0, 8'($urandom)});
    srcq[1].push_back({1'b1, 8'($urandom)});
    obs_data.delete();
    drive();
    n = 0;
    while (obs_data.size() == 0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL reset_preframe: got no strobe in %0d cycles want one", n);
    end
    rst = 1'b1;
    step();
    check_zero("reset_midframe");
    step();
    step();
    srcq[0].delete();
    srcq[1].delete();
    srcq[0].push_back({1'b0, 8'($urandom)});
    srcq[0].push_back({1'b1, 8'($urandom)});
    srcq[1].push_back({1'b1, 8'($urandom)});
    rst = 1'b0;
    model_ptr = 1;
    run_and_check("after_reset", 1'b0);
  endtask

  task automatic test_single();
    int k;
    srcq[0].push_back(9'h055);
    srcq[0].push_back(9'h1AA);
    run_and_check("single", 1'b0);
`ifdef UART_TX_ARBITER_TAG_EN
    k = 1;
`else
    k = 0;
`endif
    checks++;
    if (obs_cyc.size() <= k || obs_cyc[k] - hs_cyc != 1) begin
      failures++;
      $display("FAIL single_latency: got hs=%0d stb=%0d want stb=hs+1", hs_cyc,
               (obs_cyc.size() > k) ? obs_cyc[k] : -1);
    end
  endtask

  task automatic test_contention();
    int len;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 2; r++) begin
        srcq[r].push_back({1'b0, 8'($urandom)});
        srcq[r].push_back({1'b1, 8'($urandom)});
      end
    end
    run_and_check("contention", 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 2; r++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++)
          srcq[r].push_back({(b == len - 1), 8'($urandom)});
      end
    end
    run_and_check("contention_rand", 1'b0);
  endtask

  task automatic test_stall();
    int k;
    do_reset();
    stall_grant = 2'bxx;
    srcq[0].push_back({1'b0, 8'($urandom)});
    srcq[0].push_back({1'b1, 8'($urandom)});
    srcq[1].push_back({1'b0, 8'($urandom)});
    srcq[1].push_back({1'b1, 8'($urandom)});
    stall_arm[0] = 1'b1;
    run_and_check("stall", 1'b1);
    checks++;
    if (stall_grant !== 2'b01) begin
      failures++;
      $display("FAIL stall_grant: got %b want 01", stall_grant);
    end
`ifdef UART_TX_ARBITER_TAG_EN
    k = 1;
`else
    k = 0;
`endif
    checks++;
    if (obs_cyc.size() <= k + 1 || obs_cyc[k+1] - obs_cyc[k] < 100) begin
      failures++;
      $display("FAIL stall_hold: got spacing %0d want >=100",
               (obs_cyc.size() > k + 1) ? obs_cyc[k+1] - obs_cyc[k] : -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 4; p++) srcq[1].push_back({1'b1, 8'($urandom)});
    run_and_check("back_to_back", 1'b0);
  endtask

`ifdef UART_TX_ARBITER_TAG_EN
  task automatic test_tag();
    do_reset();
    srcq[1].push_back(9'h141);
    run_and_check("tag", 1'b0);
    checks++;
    if (obs_data.size() < 1 || obs_data[0] !== 8'hF1) begin
      failures++;
      $display("FAIL tag_byte: got %h want f1",
               (obs_data.size() > 0) ? obs_data[0] : 8'hxx);
    end
  endtask
`endif

  initial begin
    stall_cnt[0] = 0;
    stall_cnt[1] = 0;
    stall_arm[0] = 1'b0;
    stall_arm[1] = 1'b0;
    hs_cyc = -1;
    model_ptr = 1;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_back_to_back();
`ifdef UART_TX_ARBITER_TAG_EN
    test_tag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
